// File: rtl/mem_access_unit.sv
// MEM stage: issues loads/stores over a req/ack data bus, stalls while in flight, registers MEM/WB.
// Optional build macro MISALIGN_TRAP_EN traps misaligned half/word accesses instead of truncating.
module mem_access_unit #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_unsign,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        bus_err,
    output logic        misalign_exc
);

    localparam int unsigned CW = 8;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
    logic [31:0]   dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
    logic [3:0]    dmem_be_q, dmem_be_d;
    logic          wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
    logic [4:0]    wb_rd_q, wb_rd_d, rd_q, rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          bus_err_q, bus_err_d, misalign_q, misalign_d;
    logic [1:0]    size_q, size_d, lo_q, lo_d;
    logic          unsign_q, unsign_d, rw_q, rw_d;

    logic          mem_op_c, mis_c, timeout_c;
    logic [3:0]    be_c;
    logic [31:0]   wdata_c, load_c;
    logic [7:0]    ld_byte_c;
    logic [15:0]   ld_half_c;

    assign mem_op_c  = ex_mem_read | ex_mem_write;
    assign timeout_c = (cnt_q == CW'(MAX_WAIT - 1));

`ifdef MISALIGN_TRAP_EN
    assign mis_c = mem_op_c &&
                   (((ex_mem_size == 2'b01) && ex_alu_result[0]) ||
                    (ex_mem_size[1] && (ex_alu_result[1:0] != 2'b00)));
`else
    assign mis_c = 1'b0;
`endif

    // Byte enables and lane-replicated store data for the incoming op
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = ex_store_data;
        case (ex_mem_size)
            2'b00: begin
                be_c    = 4'b0001 << ex_alu_result[1:0];
                wdata_c = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                be_c    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select and extension of returned load data
    always_comb begin
        ld_byte_c = 8'(dmem_rdata >> {lo_q, 3'b000});
        ld_half_c = lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            2'b00:   load_c = unsign_q ? {24'b0, ld_byte_c} : {{24{ld_byte_c[7]}}, ld_byte_c};
            2'b01:   load_c = unsign_q ? {16'b0, ld_half_c} : {{16{ld_half_c[15]}}, ld_half_c};
            default: load_c = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_be_d      = dmem_be_q;
        dmem_wdata_d   = dmem_wdata_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        bus_err_d      = 1'b0;
        misalign_d     = 1'b0;
        size_d         = size_q;
        lo_d           = lo_q;
        unsign_d       = unsign_q;
        rd_d           = rd_q;
        rw_d           = rw_q;
        stall          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid && mem_op_c && !mis_c) begin
                    stall        = 1'b1;
                    state_d      = ST_WAIT;
                    cnt_d        = '0;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = ex_mem_write;
                    dmem_addr_d  = {ex_alu_result[31:2], 2'b00};
                    dmem_be_d    = be_c;
                    dmem_wdata_d = wdata_c;
                    size_d       = ex_mem_size;
                    lo_d         = ex_alu_result[1:0];
                    unsign_d     = ex_mem_unsign;
                    rd_d         = ex_rd;
                    rw_d         = ex_reg_write;
                end else if (ex_valid) begin
                    // Non-memory passthrough, or a trapped misaligned access
                    wb_valid_d     = 1'b1;
                    wb_rd_d        = ex_rd;
                    wb_data_d      = ex_alu_result;
                    wb_reg_write_d = ex_reg_write && !mis_c;
                    misalign_d     = mis_c;
                end
            end
            default: begin
                stall = !dmem_ack && !timeout_c;
                if (dmem_ack) begin
                    state_d    = ST_IDLE;
                    dmem_req_d = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    if (dmem_we_q) begin
                        wb_data_d = {dmem_addr_q[31:2], lo_q};
                    end else begin
                        wb_data_d      = load_c;
                        wb_reg_write_d = rw_q;
                    end
                end else if (timeout_c) begin
                    state_d    = ST_IDLE;
                    dmem_req_d = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = '0;
                    bus_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_be_q      <= '0;
            dmem_wdata_q   <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            bus_err_q      <= 1'b0;
            misalign_q     <= 1'b0;
            size_q         <= '0;
            lo_q           <= '0;
            unsign_q       <= 1'b0;
            rd_q           <= '0;
            rw_q           <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_be_q      <= dmem_be_d;
            dmem_wdata_q   <= dmem_wdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            bus_err_q      <= bus_err_d;
            misalign_q     <= misalign_d;
            size_q         <= size_d;
            lo_q           <= lo_d;
            unsign_q       <= unsign_d;
            rd_q           <= rd_d;
            rw_q           <= rw_d;
        end
    end

    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_be      = dmem_be_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign bus_err      = bus_err_q;
    assign misalign_exc = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: passthrough, lane handling, wait/timeout, reset, misalignment.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_mem_unsign, ex_reg_write;
    logic [1:0]  ex_mem_size;
    logic [31:0] ex_alu_result, ex_store_data, dmem_rdata;
    logic [4:0]  ex_rd;
    logic        stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_reg_write, bus_err, misalign_exc;
    logic [4:0]  wb_rd;

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(.MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_size(ex_mem_size), .ex_mem_unsign(ex_mem_unsign),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .bus_err(bus_err), .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic rd_op, input logic wr_op, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [4:0] rd, input logic rw);
        ex_valid      = 1'b1;
        ex_mem_read   = rd_op;
        ex_mem_write  = wr_op;
        ex_mem_size   = size;
        ex_mem_unsign = uns;
        ex_alu_result = addr;
        ex_store_data = sdata;
        ex_rd         = rd;
        ex_reg_write  = rw;
        #1;
    endtask

    // Issue a load that is acked on its first WAIT cycle; leaves the unit back in IDLE with wb loaded
    task automatic quick_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                              input logic [31:0] rdata, input logic [4:0] rd);
        present(1'b1, 1'b0, size, uns, addr, 32'h0, rd, 1'b1);
        step();
        ex_valid   = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        #1;
        step();
        dmem_ack = 1'b0;
    endtask

    initial begin
        int stall_cnt;
        reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_size = 2'b00;
        ex_mem_unsign = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_rd = '0; ex_reg_write = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_req", dmem_req, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 0);

        // 1: ADD passthrough
        present(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        check("t1_stall", stall, 0);
        step();
        ex_valid = 1'b0;
        check("t1_wb_valid", wb_valid, 1);
        check("t1_wb_data", wb_data, 32'h0000_1234);
        check("t1_wb_rd", wb_rd, 5);
        check("t1_wb_rw", wb_reg_write, 1);
        check("t1_stall_after", stall, 0);
        step();
        check("t1_idle_wb_valid", wb_valid, 0);

        // 2: LB / LBU at lane 3
        present(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
        check("t2_stall_present", stall, 1);
        step();
        ex_valid = 1'b0;
        check("t2_req", dmem_req, 1);
        check("t2_be", dmem_be, 4'b1000);
        check("t2_addr", dmem_addr, 32'h0000_0100);
        check("t2_we", dmem_we, 0);
        dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000; #1;
        check("t2_stall_ack", stall, 0);
        step();
        dmem_ack = 1'b0;
        check("t2_lb_data", wb_data, 32'hFFFF_FF80);
        check("t2_lb_valid", wb_valid, 1);
        check("t2_lb_rw", wb_reg_write, 1);
        check("t2_lb_rd", wb_rd, 7);
        check("t2_req_drop", dmem_req, 0);
        quick_load(2'b00, 1'b1, 32'h0000_0103, 32'h80FF_0000, 5'd7);
        check("t2_lbu_data", wb_data, 32'h0000_0080);
        quick_load(2'b01, 1'b0, 32'h0000_0106, 32'h8001_0000, 5'd8);
        check("lh_upper_data", wb_data, 32'hFFFF_8001);
        quick_load(2'b01, 1'b1, 32'h0000_0104, 32'h1234_F00D, 5'd8);
        check("lhu_lower_data", wb_data, 32'h0000_F00D);

        // 3: SH with ack on the 4th WAIT cycle
        stall_cnt = 0;
        present(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 5'd9, 1'b0);
        if (stall) stall_cnt++;
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (stall) stall_cnt++;
            check("t3_addr", dmem_addr, 32'h0000_0200);
            check("t3_be", dmem_be, 4'b1100);
            check("t3_wdata", dmem_wdata, 32'hABCD_ABCD);
            check("t3_we", dmem_we, 1);
            check("t3_req", dmem_req, 1);
            step();
        end
        dmem_ack = 1'b1; #1;
        if (stall) stall_cnt++;
        check("t3_stall_cycles", 32'(stall_cnt), 4);
        step();
        dmem_ack = 1'b0;
        check("t3_wb_valid", wb_valid, 1);
        check("t3_wb_data", wb_data, 32'h0000_0202);
        check("t3_wb_rw", wb_reg_write, 0);
        check("t3_req_drop", dmem_req, 0);

        // 4: LW timeout after 15 WAIT cycles
        present(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 5'd3, 1'b1);
        step();
        ex_valid = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            check("t4_stall", stall, 32'(i < 15));
            check("t4_req", dmem_req, 1);
            check("t4_no_err", bus_err, 0);
            step();
        end
        check("t4_bus_err", bus_err, 1);
        check("t4_wb_valid", wb_valid, 1);
        check("t4_wb_rw", wb_reg_write, 0);
        check("t4_req_drop", dmem_req, 0);
        step();
        check("t4_err_pulse", bus_err, 0);

        // 5: reset mid-WAIT, then a late ack
        present(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 5'd4, 1'b1);
        step();
        ex_valid = 1'b0;
        step();
        check("t5_req_before", dmem_req, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_req", dmem_req, 0);
        check("t5_addr", dmem_addr, 0);
        check("t5_be", dmem_be, 0);
        check("t5_wb_valid", wb_valid, 0);
        check("t5_wb_data", wb_data, 0);
        check("t5_stall", stall, 0);
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #1;
        check("t5_late_stall", stall, 0);
        step();
        dmem_ack = 1'b0;
        check("t5_late_wb_valid", wb_valid, 0);
        check("t5_late_req", dmem_req, 0);
        check("t5_late_data", wb_data, 0);

        // 6: LW at 0x302
        present(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0302, 32'h0, 5'd6, 1'b1);
`ifdef MISALIGN_TRAP_EN
        check("t6_stall", stall, 0);
        step();
        ex_valid = 1'b0;
        check("t6_misalign", misalign_exc, 1);
        check("t6_wb_valid", wb_valid, 1);
        check("t6_wb_rw", wb_reg_write, 0);
        check("t6_req", dmem_req, 0);
        step();
        check("t6_misalign_pulse", misalign_exc, 0);
`else
        check("t6_stall", stall, 1);
        step();
        ex_valid = 1'b0;
        check("t6_addr", dmem_addr, 32'h0000_0300);
        check("t6_be", dmem_be, 4'b1111);
        check("t6_req", dmem_req, 1);
        dmem_ack = 1'b1; dmem_rdata = 32'h1122_3344; #1;
        step();
        dmem_ack = 1'b0;
        check("t6_wb_data", wb_data, 32'h1122_3344);
        check("t6_wb_rw", wb_reg_write, 1);
        check("t6_misalign", misalign_exc, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
